regbank_sequencer: RTL and testbench
====================================

# regbank_sequencer

Command-driven access controller for the two-register 2-bit bank. Each accepted command becomes a timed sequence of `read_enable_*` / `write_enable_*` strobes on the bank's ports. Read-back values arrive on the bank's `data_out_*` buses and are captured internally. Each command completes with a response word. The block sits between the processor control path and the register bank: the bank only consumes strobes, and this block generates them.

## Interface
Parameters:
- `WIDTH`, 2: register and data width.
- `READ_LAT`, 1: cycles `read_enable_*` is held before `data_out_*` is sampled; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_op`  in  2  00 LOAD, 01 STORE, 10 MOVE, 11 SWAP.
- `cmd_src`  in  1  source register (0 = reg1, 1 = reg2).
- `cmd_dst`  in  1  destination register (0 = reg1, 1 = reg2).
- `cmd_data`  in  WIDTH  immediate for LOAD.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  WIDTH  response value.
- `write_enable_1`, `write_enable_2`  out  1  bank write strobes.
- `data_in_1`, `data_in_2`  out  WIDTH  bank write data.
- `read_enable_1`, `read_enable_2`  out  1  bank read strobes.
- `data_out_1`, `data_out_2`  in  WIDTH  bank read buses; sampled only.

## Operation
- States: IDLE, READ_A, READ_B, WRITE, RESP.
- **IDLE.** `cmd_ready`=1, and `cmd_ready` is 1 only in this state. On `cmd_valid`&`cmd_ready`, the block latches op, src, dst and data.
- **LOAD.** IDLE → WRITE → RESP.
  - WRITE: `write_enable_dst`=1 and `data_in_dst`=data.
  - `rsp_data`=data.
- **STORE.** IDLE → READ_A → RESP.
  - READ_A: `read_enable_src`=1 for `READ_LAT` cycles.
  - `data_out_src` is captured into t1 at the clock edge that ends the last READ_A cycle.
  - `rsp_data`=t1.
- **MOVE.** IDLE → READ_A (src into t1) → WRITE → RESP.
  - WRITE: `write_enable_dst`=1 and `data_in_dst`=t1.
  - `rsp_data`=t1.
  - src==dst is legal: the value is rewritten unchanged.
- **SWAP.** IDLE → READ_A → READ_B → WRITE → RESP.
  - READ_A reads reg1 into t1; READ_B reads reg2 into t2; src and dst are ignored.
  - WRITE asserts both write enables in the same cycle: `data_in_1`=t2, `data_in_2`=t1.
  - `rsp_data`=t1 (old reg1).
- **RESP.** `rsp_valid`=1 and `rsp_data` stays stable until `rsp_ready`. RESP → IDLE on `rsp_ready`.
- Strobe invariants:
  - Never both read enables high at once.
  - Never a read enable high in the same cycle as any write enable.
  - `data_in_*`=0 whenever its write enable is 0.
- A read-latency counter (2 bits) counts `READ_LAT`-1 down to 0 and reloads on entry to each READ state.

## Timing
- Reset value of every output is 0: `cmd_ready`, `rsp_valid`, `rsp_data`, all enables, all `data_in_*`. t1, t2 and the counter also clear, and the state goes to IDLE.
- `cmd_ready` becomes 1 on the first clock edge after reset deasserts.
- Latency with the command accepted at edge T, first strobe cycle T+1, `READ_LAT`=L:
  - LOAD: `rsp_valid` at T+2.
  - STORE: T+1+L.
  - MOVE: T+2+L.
  - SWAP: T+2+2L.
- A response handed off at edge R returns the block to IDLE; a new command is accepted at the earliest at R+1, so there is no overlap.
- `cmd_valid` while busy is ignored; the initiator holds the command until `cmd_ready`.
- `rsp_ready` high before `rsp_valid` has no effect.
- Reset asserted mid-sequence:
  - All strobes drop asynchronously, with no partial write completion.
  - The latched command and any pending response are discarded.

## Structure
- Shared package `regbank_seq_pkg`:
  - op encodings `OP_LOAD`/`OP_STORE`/`OP_MOVE`/`OP_SWAP`;
  - state enum;
  - register-select constants `REG1`=0, `REG2`=1.
- No sub-module: the counter and FSM are small enough to be inline.
- Bank strobes are decoded combinationally from state plus the latched select.

## Test plan
- **Reset then LOAD.** Reset low, release; LOAD dst=1, data=2'b10.
  - `write_enable_2`=1 and `data_in_2`=2'b10 at T+1.
  - `rsp_valid` at T+2 with `rsp_data`=2'b10.
- **STORE with L=1 and L=3.** Bank model reg1=2'b01; STORE src=0.
  - `read_enable_1` high for exactly L cycles.
  - `rsp_data`=2'b01 at T+1+L.
- **SWAP.** reg1=2'b11, reg2=2'b00.
  - One WRITE cycle with both write enables high, `data_in_1`=2'b00 and `data_in_2`=2'b11.
  - `rsp_data`=2'b11.
- **MOVE src==dst plus back-pressure.** reg2=2'b10, MOVE 1→1, `rsp_ready` held low 5 cycles.
  - Rewrite of 2'b10.
  - `rsp_valid` and `rsp_data` stable for all 5 cycles.
  - `cmd_ready`=0 throughout.
- **Reset mid-SWAP.** Drop `reset` during READ_B.
  - All outputs 0 immediately.
  - No write enable ever pulses.
  - After release, the next LOAD completes normally.
- **Invariant checker.** Run 1000 random commands with random `rsp_ready` and assert the strobe invariants on every cycle.

Source files
------------

// File: rtl/regbank_seq_pkg.sv
// regbank_seq_pkg: shared definitions for the register-bank access sequencer.
//   - command op encodings (OP_LOAD / OP_STORE / OP_MOVE / OP_SWAP)
//   - register-select constants (REG1 / REG2)
//   - sequencer state enum
package regbank_seq_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    localparam logic REG1 = 1'b0;
    localparam logic REG2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/regbank_sequencer.sv
// regbank_sequencer: turns one command at a time into a timed sequence of
// read/write strobes on a two-register bank and returns a response word.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_src/cmd_dst     op (LOAD/STORE/MOVE/SWAP), source and destination select
//   cmd_data                   immediate for LOAD
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   response value (0 outside the response phase)
//   write_enable_1/2           bank write strobes
//   data_in_1/2                bank write data (0 while the matching strobe is low)
//   read_enable_1/2            bank read strobes
//   data_out_1/2               bank read data, sampled at the end of a read phase
//   dbg_state                  current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The initiator holds a command stable until it is accepted;
// rsp_valid and rsp_data stay stable until rsp_ready is seen. cmd_ready is
// only high while idle, so a new command cannot overlap a pending response.
module regbank_sequencer
    import regbank_seq_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int READ_LAT = 1     // legal range 1..4 (two-bit latency counter)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_src,
    input  logic             cmd_dst,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             write_enable_1,
    output logic             write_enable_2,
    output logic [WIDTH-1:0] data_in_1,
    output logic [WIDTH-1:0] data_in_2,
    output logic             read_enable_1,
    output logic             read_enable_2,
    input  logic [WIDTH-1:0] data_out_1,
    input  logic [WIDTH-1:0] data_out_2,
    output logic [2:0]       dbg_state
);

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t           state, state_nx;
    logic             started;     // keeps cmd_ready low until the first edge after reset
    logic [1:0]       op_q;
    logic             src_q;
    logic             dst_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
    logic [1:0]       lat_cnt;
    logic [WIDTH-1:0] wdata;

    logic accept;
    logic last_read;
    assign accept    = cmd_valid & cmd_ready;
    assign last_read = (lat_cnt == 2'd0);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = (cmd_op == OP_LOAD) ? ST_WRITE : ST_READ_A;
            ST_READ_A: begin
                if (last_read) begin
                    case (op_q)
                        OP_MOVE: state_nx = ST_WRITE;
                        OP_SWAP: state_nx = ST_READ_B;
                        default: state_nx = ST_RESP;   // STORE
                    endcase
                end
            end
            ST_READ_B: if (last_read) state_nx = ST_WRITE;
            ST_WRITE:  state_nx = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started <= 1'b0;
            op_q    <= OP_LOAD;
            src_q   <= REG1;
            dst_q   <= REG1;
            data_q  <= '0;
            t1      <= '0;
            t2      <= '0;
            lat_cnt <= 2'd0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                op_q   <= cmd_op;
                src_q  <= cmd_src;
                dst_q  <= cmd_dst;
                data_q <= cmd_data;
            end
            // Reload on entry into either read state (READ_A -> READ_B included).
            if ((state_nx == ST_READ_A || state_nx == ST_READ_B) && state_nx != state)
                lat_cnt <= LAT_LOAD;
            else if ((state == ST_READ_A || state == ST_READ_B) && !last_read)
                lat_cnt <= lat_cnt - 2'd1;
            // Capture on the edge that ends the final read cycle; SWAP always reads reg1 first.
            if (state == ST_READ_A && last_read)
                t1 <= (op_q == OP_SWAP || src_q == REG1) ? data_out_1 : data_out_2;
            if (state == ST_READ_B && last_read)
                t2 <= data_out_2;
        end
    end

    // Strobes and response are pure decodes of state plus the latched command,
    // so an asynchronous reset drops them immediately.
    always_comb begin
        cmd_ready      = started && (state == ST_IDLE);
        rsp_valid      = (state == ST_RESP);
        rsp_data       = '0;
        read_enable_1  = 1'b0;
        read_enable_2  = 1'b0;
        write_enable_1 = 1'b0;
        write_enable_2 = 1'b0;
        data_in_1      = '0;
        data_in_2      = '0;
        wdata          = (op_q == OP_LOAD) ? data_q : t1;
        case (state)
            ST_READ_A: begin
                if (op_q == OP_SWAP || src_q == REG1) read_enable_1 = 1'b1;
                else                                  read_enable_2 = 1'b1;
            end
            ST_READ_B: read_enable_2 = 1'b1;
            ST_WRITE: begin
                if (op_q == OP_SWAP) begin
                    write_enable_1 = 1'b1;
                    write_enable_2 = 1'b1;
                    data_in_1      = t2;
                    data_in_2      = t1;
                end else if (dst_q == REG1) begin
                    write_enable_1 = 1'b1;
                    data_in_1      = wdata;
                end else begin
                    write_enable_2 = 1'b1;
                    data_in_2      = wdata;
                end
            end
            ST_RESP:   rsp_data = wdata;   // LOAD: immediate, all others: t1
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regbank_sequencer.sv
// tb_regbank_sequencer: two sequencer instances (READ_LAT 3 and 1), each
// attached to its own behavioural two-register bank.
module tb_regbank_sequencer;
    import regbank_seq_pkg::*;

    localparam int W    = 2;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         cmd_valid[2], cmd_ready[2], cmd_src[2], cmd_dst[2];
    logic [1:0]   cmd_op[2];
    logic [W-1:0] cmd_data[2], rsp_data[2];
    logic         rsp_valid[2], rsp_ready[2];
    logic         we1[2], we2[2], re1[2], re2[2];
    logic [W-1:0] din1[2], din2[2], dout1[2], dout2[2];
    logic [2:0]   dbg[2];

    regbank_sequencer #(.WIDTH(W), .READ_LAT(LAT0)) u_dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_src(cmd_src[0]), .cmd_dst(cmd_dst[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .write_enable_1(we1[0]), .write_enable_2(we2[0]),
        .data_in_1(din1[0]), .data_in_2(din2[0]),
        .read_enable_1(re1[0]), .read_enable_2(re2[0]),
        .data_out_1(dout1[0]), .data_out_2(dout2[0]), .dbg_state(dbg[0])
    );

    regbank_sequencer #(.WIDTH(W), .READ_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_src(cmd_src[1]), .cmd_dst(cmd_dst[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .write_enable_1(we1[1]), .write_enable_2(we2[1]),
        .data_in_1(din1[1]), .data_in_2(din2[1]),
        .read_enable_1(re1[1]), .read_enable_2(re2[1]),
        .data_out_1(dout1[1]), .data_out_2(dout2[1]), .dbg_state(dbg[1])
    );

    // ---------------- bank models ----------------
    logic         bank_clr;
    logic [W-1:0] bank1[2], bank2[2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (bank_clr) begin
                bank1[d] <= '0;
                bank2[d] <= '0;
            end else begin
                if (we1[d]) bank1[d] <= din1[d];
                if (we2[d]) bank2[d] <= din2[d];
            end
        end
    end
    assign dout1[0] = bank1[0];
    assign dout2[0] = bank2[0];
    assign dout1[1] = bank1[1];
    assign dout2[1] = bank2[1];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mdl[2][2];          // reference register contents per instance
    int last_rd1, last_rd2, last_wr1, last_wr2, last_both;
    logic [W-1:0] last_wd1, last_wd2;
    logic we_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check_quiet(input int d, input string tag);
        check({tag, "_cmd_ready"}, cmd_ready[d], 0);
        check({tag, "_rsp_valid"}, rsp_valid[d], 0);
        check({tag, "_rsp_data"},  rsp_data[d], 0);
        check({tag, "_re1"}, re1[d], 0);
        check({tag, "_re2"}, re2[d], 0);
        check({tag, "_we1"}, we1[d], 0);
        check({tag, "_we2"}, we2[d], 0);
        check({tag, "_din1"}, din1[d], 0);
        check({tag, "_din2"}, din2[d], 0);
        check({tag, "_state"}, dbg[d], ST_IDLE);
    endtask

    // Strobe invariants, every cycle, both instances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check("inv_two_reads", re1[d] & re2[d], 0);
            check("inv_read_write", (re1[d] | re2[d]) & (we1[d] | we2[d]), 0);
            if (!we1[d]) check("inv_din1_zero", din1[d], 0);
            if (!we2[d]) check("inv_din2_zero", din2[d], 0);
            check("inv_ready_vs_rsp", cmd_ready[d] & rsp_valid[d], 0);
        end
    end

    always @(posedge we1[0] or posedge we2[0]) we_pulse = 1'b1;

    // ---------------- driver ----------------
    // Runs one command end to end and checks it against the register model.
    task automatic run_cmd(input int d, input logic [1:0] op, input logic src, input logic dst,
                           input logic [W-1:0] data, input int hold, input bit noise,
                           output logic [W-1:0] got, output int lat);
        int L = lat_of(d);
        int budget = 0;
        int exp_lat, exp_rd1, exp_rd2, exp_wr1, exp_wr2;
        logic [W-1:0] e, r1, r2, held;
        logic rd_op, wr_op;
        r1 = mdl[d][0];
        r2 = mdl[d][1];
        case (op)
            OP_LOAD:  begin e = data;         mdl[d][dst] = data; exp_lat = 2;         end
            OP_STORE: begin e = mdl[d][src];                      exp_lat = 1 + L;     end
            OP_MOVE:  begin e = mdl[d][src];  mdl[d][dst] = e;    exp_lat = 2 + L;     end
            default:  begin e = r1; mdl[d][0] = r2; mdl[d][1] = r1; exp_lat = 2 + 2 * L; end
        endcase
        rd_op   = (op == OP_STORE) || (op == OP_MOVE);
        wr_op   = (op == OP_LOAD) || (op == OP_MOVE);
        exp_rd1 = (op == OP_SWAP || (rd_op && src == 1'b0)) ? L : 0;
        exp_rd2 = (op == OP_SWAP || (rd_op && src == 1'b1)) ? L : 0;
        exp_wr1 = (op == OP_SWAP || (wr_op && dst == 1'b0)) ? 1 : 0;
        exp_wr2 = (op == OP_SWAP || (wr_op && dst == 1'b1)) ? 1 : 0;
        exp_q.push_back(e);
        last_rd1 = 0; last_rd2 = 0; last_wr1 = 0; last_wr2 = 0; last_both = 0;
        last_wd1 = '0; last_wd2 = '0;
        got = '0;
        lat = 0;

        @(negedge clk);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_src[d]   = src;
        cmd_dst[d]   = dst;
        cmd_data[d]  = data;
        while (!cmd_ready[d] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready[d]) begin
            note_fail("cmd_accept");
            cmd_valid[d] = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            if (re1[d]) last_rd1++;
            if (re2[d]) last_rd2++;
            if (we1[d]) begin last_wr1++; last_wd1 = din1[d]; end
            if (we2[d]) begin last_wr2++; last_wd2 = din2[d]; end
            if (we1[d] && we2[d]) last_both++;
            if (noise) rsp_ready[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) begin
            note_fail("rsp_wait");
            rsp_ready[d] = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        check("latency", lat, exp_lat);
        check("read1_cycles", last_rd1, exp_rd1);
        check("read2_cycles", last_rd2, exp_rd2);
        check("write1_cycles", last_wr1, exp_wr1);
        check("write2_cycles", last_wr2, exp_wr2);

        rsp_ready[d] = 1'b0;
        held = rsp_data[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid[d], 1);
            check("hold_rsp_data", rsp_data[d], held);
            check("hold_cmd_ready", cmd_ready[d], 0);
        end
        rsp_ready[d] = 1'b1;
        got = rsp_data[d];
        check("rsp_data", got, exp_q.pop_front());
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_dropped", rsp_valid[d], 0);
        check("ready_after_rsp", cmd_ready[d], 1);
        check("bank_reg1", bank1[d], mdl[d][0]);
        check("bank_reg2", bank2[d], mdl[d][1]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]   op;
        logic         src;
        logic         dst;
        logic [W-1:0] data;
        logic [W-1:0] exp_rsp;
        int           exp_lat;
    } vec_t;
    vec_t vecs[9];

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] got;
        int lat;

        // Table for instance 0 (READ_LAT=3), starting from reg1=00, reg2=10.
        vecs[0] = '{OP_LOAD,  1'b0, 1'b0, 2'b01, 2'b01, 2};
        vecs[1] = '{OP_STORE, 1'b0, 1'b0, 2'b00, 2'b01, 4};
        vecs[2] = '{OP_STORE, 1'b1, 1'b0, 2'b00, 2'b10, 4};
        vecs[3] = '{OP_MOVE,  1'b0, 1'b1, 2'b00, 2'b01, 5};
        vecs[4] = '{OP_LOAD,  1'b0, 1'b1, 2'b11, 2'b11, 2};
        vecs[5] = '{OP_SWAP,  1'b1, 1'b0, 2'b00, 2'b01, 8};
        vecs[6] = '{OP_STORE, 1'b1, 1'b0, 2'b00, 2'b01, 4};
        vecs[7] = '{OP_MOVE,  1'b1, 1'b0, 2'b00, 2'b01, 5};
        vecs[8] = '{OP_STORE, 1'b0, 1'b0, 2'b00, 2'b01, 4};

        reset = 1'b0;
        bank_clr = 1'b1;
        we_pulse = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_op[d] = 2'b00; cmd_src[d] = 1'b0;
            cmd_dst[d] = 1'b0; cmd_data[d] = '0; rsp_ready[d] = 1'b0;
            mdl[d][0] = '0; mdl[d][1] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_quiet(d, "reset");
        bank_clr = 1'b0;
        reset = 1'b1;
        #1;
        check("ready_before_edge0", cmd_ready[0], 0);
        check("ready_before_edge1", cmd_ready[1], 0);
        @(negedge clk);
        check("ready_after_edge0", cmd_ready[0], 1);
        check("ready_after_edge1", cmd_ready[1], 1);

        // Reset then LOAD dst=reg2, data=10.
        run_cmd(0, OP_LOAD, 1'b0, 1'b1, 2'b10, 0, 1'b0, got, lat);
        check("load_rsp", got, 2'b10);
        check("load_wd2", last_wd2, 2'b10);
        check("load_lat", lat, 2);

        for (int i = 0; i < 9; i++) begin
            run_cmd(0, vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].data, i % 3, 1'b0, got, lat);
            check("vec_rsp", got, vecs[i].exp_rsp);
            check("vec_lat", lat, vecs[i].exp_lat);
        end

        // STORE with L=1 and L=3, reg1=01.
        run_cmd(1, OP_LOAD, 1'b0, 1'b0, 2'b01, 0, 1'b0, got, lat);
        run_cmd(1, OP_STORE, 1'b0, 1'b0, 2'b00, 0, 1'b0, got, lat);
        check("store_l1_rsp", got, 2'b01);
        check("store_l1_reads", last_rd1, 1);
        check("store_l1_lat", lat, 2);
        run_cmd(0, OP_LOAD, 1'b0, 1'b0, 2'b01, 0, 1'b0, got, lat);
        run_cmd(0, OP_STORE, 1'b0, 1'b0, 2'b00, 0, 1'b0, got, lat);
        check("store_l3_rsp", got, 2'b01);
        check("store_l3_reads", last_rd1, 3);
        check("store_l3_lat", lat, 4);

        // SWAP reg1=11, reg2=00.
        run_cmd(0, OP_LOAD, 1'b0, 1'b0, 2'b11, 0, 1'b0, got, lat);
        run_cmd(0, OP_LOAD, 1'b0, 1'b1, 2'b00, 0, 1'b0, got, lat);
        run_cmd(0, OP_SWAP, 1'b0, 1'b0, 2'b00, 0, 1'b0, got, lat);
        check("swap_rsp", got, 2'b11);
        check("swap_both_cycles", last_both, 1);
        check("swap_din1", last_wd1, 2'b00);
        check("swap_din2", last_wd2, 2'b11);

        // MOVE reg2 -> reg2 with five cycles of back-pressure.
        run_cmd(0, OP_LOAD, 1'b0, 1'b1, 2'b10, 0, 1'b0, got, lat);
        run_cmd(0, OP_MOVE, 1'b1, 1'b1, 2'b00, 5, 1'b0, got, lat);
        check("move_rsp", got, 2'b10);
        check("move_rewrite", last_wd2, 2'b10);
        check("move_write_cycles", last_wr2, 1);

        // Reset dropped during READ_B of a SWAP.
        run_cmd(0, OP_LOAD, 1'b0, 1'b0, 2'b01, 0, 1'b0, got, lat);
        run_cmd(0, OP_LOAD, 1'b0, 1'b1, 2'b10, 0, 1'b0, got, lat);
        we_pulse = 1'b0;
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OP_SWAP;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (LAT0) @(negedge clk);
        check("midswap_in_read_b", re2[0], 1);
        #2;
        reset = 1'b0;
        #1;
        check_quiet(0, "midswap_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midswap_no_write", we_pulse, 0);
        check("midswap_reg1", bank1[0], mdl[0][0]);
        check("midswap_reg2", bank2[0], mdl[0][1]);
        check("midswap_ready", cmd_ready[0], 1);
        run_cmd(0, OP_LOAD, 1'b0, 1'b0, 2'b11, 0, 1'b0, got, lat);
        check("post_reset_load", got, 2'b11);

        // Random commands with random response back-pressure.
        for (int i = 0; i < 1000; i++) begin
            run_cmd((i < 600) ? 0 : 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), W'($urandom_range(0, 3)),
                    $urandom_range(0, 3), 1'b1, got, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "time limit");
    end

endmodule
